// File: rtl/mem_port_sched_if.sv
// Bundle of the IF/MEM request ports and the single-port RAM side of the scheduler.
// The slave modport is the scheduler; the master modport is the surrounding pipeline and memory.
interface mem_port_sched_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          if_ack;
   logic          mem_rd;
   logic          mem_wr;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack;
   logic          stall_if;
   logic          stall_mem;
   logic          ram_en;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;
   logic          ram_ready;

   modport slave (
      input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, ram_rdata, ram_ready,
      output if_rdata, if_ack, mem_rdata, mem_ack, stall_if, stall_mem,
             ram_en, ram_we, ram_addr, ram_wdata
   );

   modport master (
      output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, ram_rdata, ram_ready,
      input  if_rdata, if_ack, mem_rdata, mem_ack, stall_if, stall_mem,
             ram_en, ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/mem_port_sched.sv
// Arbitrates one single-port memory between instruction fetch and the load/store stage.
// MEM wins by default; after STARVE_MAX back-to-back MEM grants against a waiting fetch, IF is forced in.
module mem_port_sched #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 3
) (
   input  logic            clk,
   input  logic            clrn,
   mem_port_sched_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BUS_IF, BUS_MEM, DONE} state_e;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_e        state_q,     state_d;
   logic          grant_if_q,  grant_if_d;
   logic          we_q,        we_d;
   logic [AW-1:0] addr_q,      addr_d;
   logic [DW-1:0] wdata_q,     wdata_d;
   logic [DW-1:0] if_rdata_q,  if_rdata_d;
   logic [DW-1:0] mem_rdata_q, mem_rdata_d;
   logic [3:0]    starve_q,    starve_d;
   logic          mreq;

   assign mreq = bus.mem_rd | bus.mem_wr;

   always_comb begin
      // NOTE: every variable gets its hold value first so no path through the case infers a latch.
      state_d     = state_q;
      grant_if_d  = grant_if_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      starve_d    = starve_q;

      unique case (state_q)
         IDLE: begin
            if (bus.if_req && (starve_q == STARVE_LIM)) begin
               state_d    = BUS_IF;
               grant_if_d = 1'b1;
               we_d       = 1'b0;
               addr_d     = bus.if_addr;
               starve_d   = '0;
            end else if (mreq) begin
               state_d    = BUS_MEM;
               grant_if_d = 1'b0;
               we_d       = bus.mem_wr;
               addr_d     = bus.mem_addr;
               wdata_d    = bus.mem_wdata;
               // Reaching the limit forces IF on the next grant, so the count saturates there.
               starve_d   = bus.if_req ? starve_q + 4'd1 : 4'd0;
            end else if (bus.if_req) begin
               state_d    = BUS_IF;
               grant_if_d = 1'b1;
               we_d       = 1'b0;
               addr_d     = bus.if_addr;
               starve_d   = '0;
            end
         end
         BUS_IF, BUS_MEM: begin
            if (bus.ram_ready) begin
               state_d = DONE;
               if (state_q == BUS_IF) if_rdata_d = bus.ram_rdata;
               else if (!we_q)        mem_rdata_d = bus.ram_rdata;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q     <= IDLE;
         grant_if_q  <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
         starve_q    <= '0;
      end else begin
         state_q     <= state_d;
         grant_if_q  <= grant_if_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
         starve_q    <= starve_d;
      end
   end

   // Strobes decode straight from the state register, so reset clears them without waiting for a clock.
   assign bus.ram_en    = (state_q == BUS_IF) || (state_q == BUS_MEM);
   assign bus.ram_we    = bus.ram_en & we_q;
   assign bus.ram_addr  = addr_q;
   assign bus.ram_wdata = wdata_q;
   assign bus.if_ack    = (state_q == DONE) &  grant_if_q;
   assign bus.mem_ack   = (state_q == DONE) & ~grant_if_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.mem_rdata = mem_rdata_q;
   assign bus.stall_if  = bus.if_req & ~bus.if_ack;
   assign bus.stall_mem = mreq & ~bus.mem_ack;
endmodule
